// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Purpose : Shared constants and helper functions for the parametrised
//           single-clock FIFO (sync_fifo_param and fifo_ptr_ctrl).
// Contents:
//   DEF_DATA_W  default data word width
//   DEF_DEPTH   default number of entries
//   clog2()     ceiling log2, usable in constant expressions
//   cnt_width() width of an occupancy counter able to hold 0..depth
//   is_pow2()   true when a value is a power of two and >= 2
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_DEPTH  = 8;

  // Ceiling log2; clog2(1) is 0, clog2(8) is 3, clog2(9) is 4.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

  // The count must represent DEPTH itself, hence one bit more than the
  // pointer width.
  function automatic int cnt_width(input int depth);
    return clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value >= 2) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ptr_ctrl
// Purpose : Bookkeeping half of the FIFO. Owns the read/write pointers, the
//           occupancy count, the status flags and the over/underflow pulses.
//           It never touches data; the top level holds the storage array.
// Parameters:
//   DEPTH      number of entries, power of two, >= 2
//   AF_THRESH  almost_full when count >= AF_THRESH (1..DEPTH)
//   AE_THRESH  almost_empty when count <= AE_THRESH (0..DEPTH-1)
// Ports:
//   clk           in   rising-edge clock
//   clear         in   synchronous active-high reset
//   wr_en         in   push request
//   rd_en         in   pop request
//   push_ok       out  push accepted this cycle (combinational)
//   pop_ok        out  pop accepted this cycle (combinational)
//   wr_ptr        out  storage index for the next push
//   rd_ptr        out  storage index of the current head
//   count         out  occupancy 0..DEPTH
//   empty         out  count == 0
//   full          out  count == DEPTH
//   almost_empty  out  count <= AE_THRESH
//   almost_full   out  count >= AF_THRESH
//   overflow      out  one-cycle pulse after a rejected push
//   underflow     out  one-cycle pulse after a rejected pop
// -----------------------------------------------------------------------------
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1
) (
  input  logic                          clk,
  input  logic                          clear,
  input  logic                          wr_en,
  input  logic                          rd_en,
  output logic                          push_ok,
  output logic                          pop_ok,
  output logic [clog2(DEPTH)-1:0]       wr_ptr,
  output logic [clog2(DEPTH)-1:0]       rd_ptr,
  output logic [cnt_width(DEPTH)-1:0]   count,
  output logic                          empty,
  output logic                          full,
  output logic                          almost_empty,
  output logic                          almost_full,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  // Reject nonsensical configurations while elaborating rather than letting
  // the flags silently misbehave.
  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("fifo_ptr_ctrl: DEPTH=%0d must be a power of two >= 2", DEPTH);
  end
  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
    $error("fifo_ptr_ctrl: AF_THRESH=%0d outside 1..%0d", AF_THRESH, DEPTH);
  end
  if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
    $error("fifo_ptr_ctrl: AE_THRESH=%0d outside 0..%0d", AE_THRESH, DEPTH - 1);
  end

  // A pop frees a slot in the same cycle, so a full FIFO can still take a
  // push when it is also being read.
  assign pop_ok  = rd_en & ~empty;
  assign push_ok = wr_en & (~full | pop_ok);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Occupancy moves by push_ok - pop_ok; a simultaneous push and pop
  // leaves it unchanged.
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Error pulses are registered so they line up with the count that
  // results from the same edge.
  always_ff @(posedge clk) begin
    if (clear) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en & ~push_ok;
      underflow <= rd_en & ~pop_ok;
    end
  end

  assign empty        = (count == '0);
  assign full         = (count == DEPTH_C);
  assign almost_empty = (count <= AE_C);
  assign almost_full  = (count >= AF_C);

endmodule

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Purpose : Parametrised single-clock FIFO between a producer and a consumer
//           in the same clock domain. Independent push/pop strobes, occupancy
//           count, programmable almost flags and over/underflow pulses.
// Configuration macro:
//   FIFO_FWFT_EN  defined   -> first-word fall-through: dout shows the head
//                              entry combinationally (0 when empty) and
//                              rd_en acknowledges it.
//                 undefined -> standard mode: dout is loaded on an accepted
//                              pop and holds the last popped word otherwise.
// Parameters:
//   DATA_W     data word width, >= 1
//   DEPTH      entries, power of two, >= 2
//   AF_THRESH  almost_full threshold (count >= AF_THRESH)
//   AE_THRESH  almost_empty threshold (count <= AE_THRESH)
// Ports:
//   clk           in   rising-edge clock
//   clear         in   synchronous active-high reset, wins over wr_en/rd_en
//   wr_en         in   push request
//   din           in   push data
//   rd_en         in   pop request
//   dout          out  read data
//   count         out  occupancy 0..DEPTH
//   empty         out  count == 0
//   full          out  count == DEPTH
//   almost_empty  out  count <= AE_THRESH
//   almost_full   out  count >= AF_THRESH
//   overflow      out  one-cycle pulse after a rejected push
//   underflow     out  one-cycle pulse after a rejected pop
// -----------------------------------------------------------------------------
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1
) (
  input  logic                          clk,
  input  logic                          clear,
  input  logic                          wr_en,
  input  logic [DATA_W-1:0]             din,
  input  logic                          rd_en,
  output logic [DATA_W-1:0]             dout,
  output logic [cnt_width(DEPTH)-1:0]   count,
  output logic                          empty,
  output logic                          full,
  output logic                          almost_empty,
  output logic                          almost_full,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = clog2(DEPTH);

  if (DATA_W < 1) begin : g_bad_width
    $error("sync_fifo_param: DATA_W=%0d must be >= 1", DATA_W);
  end

  logic              push_ok;
  logic              pop_ok;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  fifo_ptr_ctrl #(
    .DEPTH     (DEPTH),
    .AF_THRESH (AF_THRESH),
    .AE_THRESH (AE_THRESH)
  ) u_ptr_ctrl (
    .clk          (clk),
    .clear        (clear),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .push_ok      (push_ok),
    .pop_ok       (pop_ok),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // Storage is deliberately not reset; clearing the pointers is enough to
  // discard the contents. Writes are suppressed during clear so the array
  // only ever changes on an accepted push.
  always_ff @(posedge clk) begin
    if (push_ok && !clear) begin
      mem[wr_ptr] <= din;
    end
  end

`ifdef FIFO_FWFT_EN
  // Fall-through: the head entry is visible as soon as it exists. Forcing 0
  // when empty keeps stale array contents off the bus.
  always_comb begin
    dout = '0;
    if (!empty) begin
      dout = mem[rd_ptr];
    end
  end
`else
  // Standard mode: the word appears one cycle after the accepted pop and is
  // held until the next one. On a full FIFO with a simultaneous push the
  // read sees the old entry because the array write is also non-blocking.
  always_ff @(posedge clk) begin
    if (clear) begin
      dout <= '0;
    end else if (pop_ok) begin
      dout <= mem[rd_ptr];
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
// Purpose : Directed self-checking bench for sync_fifo_param with DATA_W=4,
//           DEPTH=8 and default thresholds. Builds for both read modes; the
//           FIFO_FWFT_EN macro selects the expected dout timing.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;
  import fifo_pkg::*;

  localparam int DATA_W = 4;
  localparam int DEPTH  = 8;
  localparam int CW     = cnt_width(DEPTH);

  logic              clk = 1'b0;
  logic              clear;
  logic              wr_en;
  logic [DATA_W-1:0] din;
  logic              rd_en;
  logic [DATA_W-1:0] dout;
  logic [CW-1:0]     count;
  logic              empty;
  logic              full;
  logic              almost_empty;
  logic              almost_full;
  logic              overflow;
  logic              underflow;

  int checks_total  = 0;
  int checks_passed = 0;

  sync_fifo_param #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .AF_THRESH (DEPTH - 1),
    .AE_THRESH (1)
  ) dut (
    .clk          (clk),
    .clear        (clear),
    .wr_en        (wr_en),
    .din          (din),
    .rd_en        (rd_en),
    .dout         (dout),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then settle 1 ns past the rising edge so the
  // registered outputs of that edge can be sampled.
  task automatic applyStimulus(input logic clr, input logic wr,
                               input logic [DATA_W-1:0] d, input logic rd);
    clear = clr;
    wr_en = wr;
    din   = d;
    rd_en = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks_total++;
    assert (observed === expected) checks_passed++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  task automatic checkStatus(input string tag, input int exp_count,
                             input logic exp_ovf, input logic exp_unf);
    checkOutput({tag, " count"}, 32'(count), 32'(exp_count));
    checkOutput({tag, " empty"}, 32'(empty), 32'(exp_count == 0));
    checkOutput({tag, " full"}, 32'(full), 32'(exp_count == DEPTH));
    checkOutput({tag, " almost_empty"}, 32'(almost_empty), 32'(exp_count <= 1));
    checkOutput({tag, " almost_full"}, 32'(almost_full), 32'(exp_count >= DEPTH - 1));
    checkOutput({tag, " overflow"}, 32'(overflow), 32'(exp_ovf));
    checkOutput({tag, " underflow"}, 32'(underflow), 32'(exp_unf));
  endtask

  initial begin
    clear = 1'b1;
    wr_en = 1'b0;
    din   = '0;
    rd_en = 1'b0;

    // Reset held for two cycles, then released.
    $display("[TB] reset");
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
    checkStatus("reset", 0, 1'b0, 1'b0);
    checkOutput("reset dout", 32'(dout), 32'd0);

    // Fill with 1..8, then one rejected push.
    $display("[TB] fill and overflow");
    for (int i = 1; i <= DEPTH; i++) begin
      applyStimulus(1'b0, 1'b1, 4'(i), 1'b0);
      checkStatus("fill", i, 1'b0, 1'b0);
    end
`ifdef FIFO_FWFT_EN
    checkOutput("fill head dout", 32'(dout), 32'd1);
`else
    checkOutput("fill dout held", 32'(dout), 32'd0);
`endif
    applyStimulus(1'b0, 1'b1, 4'd9, 1'b0);
    checkStatus("overflow pulse", DEPTH, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
    checkStatus("overflow drop", DEPTH, 1'b0, 1'b0);

    // Drain in order, then one rejected pop.
    $display("[TB] drain and underflow");
    for (int i = 1; i <= DEPTH; i++) begin
`ifdef FIFO_FWFT_EN
      checkOutput("drain head", 32'(dout), 32'(i));
`endif
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b1);
`ifndef FIFO_FWFT_EN
      checkOutput("drain dout", 32'(dout), 32'(i));
`endif
      checkOutput("drain count", 32'(count), 32'(DEPTH - i));
    end
    checkStatus("drained", 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1);
    checkStatus("underflow pulse", 0, 1'b0, 1'b1);
`ifdef FIFO_FWFT_EN
    checkOutput("empty dout", 32'(dout), 32'd0);
`else
    checkOutput("underflow dout held", 32'(dout), 32'd8);
`endif
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
    checkStatus("underflow drop", 0, 1'b0, 1'b0);

    // Full FIFO with simultaneous push and pop of 10..13.
    $display("[TB] full simultaneous push/pop");
    for (int i = 1; i <= DEPTH; i++) begin
      applyStimulus(1'b0, 1'b1, 4'(i), 1'b0);
    end
    checkStatus("refill", DEPTH, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
`ifdef FIFO_FWFT_EN
      checkOutput("full rw head", 32'(dout), 32'(i));
`endif
      applyStimulus(1'b0, 1'b1, 4'(9 + i), 1'b1);
`ifndef FIFO_FWFT_EN
      checkOutput("full rw dout", 32'(dout), 32'(i));
`endif
      checkStatus("full rw", DEPTH, 1'b0, 1'b0);
    end
    for (int i = 0; i < DEPTH; i++) begin
      logic [3:0] exp_val;
      exp_val = (i < 4) ? 4'(5 + i) : 4'(6 + i);
`ifdef FIFO_FWFT_EN
      checkOutput("order head", 32'(dout), 32'(exp_val));
`endif
      applyStimulus(1'b0, 1'b0, 4'd0, 1'b1);
`ifndef FIFO_FWFT_EN
      checkOutput("order dout", 32'(dout), 32'(exp_val));
`endif
    end
    checkStatus("order drained", 0, 1'b0, 1'b0);

    // Empty FIFO with simultaneous push and pop: push wins, pop rejected.
    $display("[TB] empty simultaneous push/pop");
    applyStimulus(1'b0, 1'b1, 4'd5, 1'b1);
    checkStatus("empty rw", 1, 1'b0, 1'b1);
`ifdef FIFO_FWFT_EN
    checkOutput("empty rw head", 32'(dout), 32'd5);
`else
    checkOutput("empty rw dout held", 32'(dout), 32'd13);
`endif
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1);
`ifndef FIFO_FWFT_EN
    checkOutput("empty rw pop", 32'(dout), 32'd5);
`endif
    checkStatus("empty rw popped", 0, 1'b0, 1'b0);

    // Alternating push/pop across pointer wrap, then clear at count 3.
    $display("[TB] wrap and clear");
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) begin
        applyStimulus(1'b0, 1'b1, 4'(i / 2 + 1), 1'b0);
        checkOutput("wrap push count", 32'(count), 32'd1);
`ifdef FIFO_FWFT_EN
        checkOutput("wrap head", 32'(dout), 32'(i / 2 + 1));
`endif
      end else begin
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1);
        checkOutput("wrap pop count", 32'(count), 32'd0);
`ifndef FIFO_FWFT_EN
        checkOutput("wrap dout", 32'(dout), 32'(i / 2 + 1));
`endif
      end
    end
    applyStimulus(1'b0, 1'b1, 4'd3, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'd4, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'd5, 1'b0);
    checkStatus("pre clear", 3, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'd9, 1'b1);
    checkStatus("clear", 0, 1'b0, 1'b0);
    checkOutput("clear dout", 32'(dout), 32'd0);
    applyStimulus(1'b0, 1'b1, 4'd6, 1'b0);
    checkStatus("post clear push", 1, 1'b0, 1'b0);
`ifdef FIFO_FWFT_EN
    checkOutput("post clear head", 32'(dout), 32'd6);
`endif
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1);
`ifndef FIFO_FWFT_EN
    checkOutput("post clear dout", 32'(dout), 32'd6);
`endif
    checkStatus("post clear pop", 0, 1'b0, 1'b0);

    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
